// File: rtl/lib_allocator_onehot_rr.sv
// Separable switch allocator: one round-robin arbiter per output drives a one-hot crossbar select.
// Define ALLOC_PACKET_LOCK_EN to hold each grant until the packet's last flit (packet-level locking).
module lib_allocator_onehot_rr #(
    parameter int N = 5,
    parameter int M = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_ce,
    input  logic [0:N-1][0:M-1] i_req,
    input  logic [0:N-1]        i_last,
    output logic [0:M-1][0:N-1] o_sel,
    output logic [0:N-1]        o_gnt
);
    localparam int PW = $clog2(N);
    typedef logic [PW-1:0] ptr_t;

`ifdef ALLOC_PACKET_LOCK_EN
    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t state_q [M];
    state_t state_d [M];
    ptr_t   own_q   [M];
    ptr_t   own_d   [M];
`endif

    logic [0:N-1][0:M-1] req_oh;
    logic [0:M-1][0:N-1] req_col;
    logic [0:M-1][0:N-1] win_oh;
    logic [0:M-1]        win_vld;
    ptr_t                win_idx [M];

    logic [0:M-1][0:N-1] sel_q, sel_d;
    logic [0:N-1]        gnt_q, gnt_d;
    ptr_t                ptr_q [M];
    ptr_t                ptr_d [M];

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(N - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Scanning from the top down lets the lowest set element of each row win.
    always_comb begin
        req_oh = '0;
        for (int n = 0; n < N; n++) begin
            for (int m = M - 1; m >= 0; m--) begin
                if (i_req[n][m]) begin
                    req_oh[n]    = '0;
                    req_oh[n][m] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        req_col = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                req_col[m][n] = req_oh[n][m];
            end
        end
    end

    // Candidates are visited from ptr+N-1 down to ptr, so the last hit is the first at or after ptr.
    always_comb begin
        int   s;
        ptr_t j;
        s       = 0;
        j       = '0;
        win_vld = '0;
        win_oh  = '0;
        for (int m = 0; m < M; m++) begin
            win_idx[m] = '0;
            for (int k = N - 1; k >= 0; k--) begin
                s = int'(ptr_q[m]) + k;
                if (s >= N) begin
                    s = s - N;
                end
                j = ptr_t'(s);
                if (req_col[m][j]) begin
                    win_vld[m]    = 1'b1;
                    win_oh[m]     = '0;
                    win_oh[m][j]  = 1'b1;
                    win_idx[m]    = j;
                end
            end
        end
    end

    // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned (no latches).
    always_comb begin
        sel_d = sel_q;
        gnt_d = '0;
        for (int m = 0; m < M; m++) begin
            ptr_d[m] = ptr_q[m];
`ifdef ALLOC_PACKET_LOCK_EN
            state_d[m] = state_q[m];
            own_d[m]   = own_q[m];
`endif
        end

        if (i_ce) begin
            for (int m = 0; m < M; m++) begin
`ifdef ALLOC_PACKET_LOCK_EN
                case (state_q[m])
                    S_IDLE: begin
                        if (win_vld[m]) begin
                            sel_d[m]   = win_oh[m];
                            own_d[m]   = win_idx[m];
                            state_d[m] = S_LOCKED;
                        end
                    end
                    S_LOCKED: begin
                        // Tail flit or withdrawn request from the owner ends the packet.
                        if (|(sel_q[m] & (i_last | ~req_col[m]))) begin
                            sel_d[m]   = '0;
                            ptr_d[m]   = ptr_inc(own_q[m]);
                            state_d[m] = S_IDLE;
                        end
                    end
                    default: state_d[m] = S_IDLE;
                endcase
`else
                sel_d[m] = win_oh[m];
                if (win_vld[m]) begin
                    ptr_d[m] = ptr_inc(win_idx[m]);
                end
`endif
            end
        end

        for (int n = 0; n < N; n++) begin
            for (int m = 0; m < M; m++) begin
                gnt_d[n] = gnt_d[n] | sel_d[m][n];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every arbiter samples the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q <= '0;
            gnt_q <= '0;
            for (int m = 0; m < M; m++) begin
                ptr_q[m] <= '0;
`ifdef ALLOC_PACKET_LOCK_EN
                state_q[m] <= S_IDLE;
                own_q[m]   <= '0;
`endif
            end
        end else begin
            sel_q <= sel_d;
            gnt_q <= gnt_d;
            for (int m = 0; m < M; m++) begin
                ptr_q[m] <= ptr_d[m];
`ifdef ALLOC_PACKET_LOCK_EN
                state_q[m] <= state_d[m];
                own_q[m]   <= own_d[m];
`endif
            end
        end
    end

    assign o_sel = sel_q;
    assign o_gnt = gnt_q;

endmodule

// File: tb/tb_lib_allocator_onehot_rr.sv
// Directed bench for lib_allocator_onehot_rr (N=5, M=5); picks packet-lock or flit-level
// scenarios according to ALLOC_PACKET_LOCK_EN.
module tb_lib_allocator_onehot_rr;
    localparam int N = 5;
    localparam int M = 5;

    logic                clk;
    logic                reset;
    logic                ce;
    logic [0:N-1][0:M-1] req;
    logic [0:N-1]        last;
    logic [0:M-1][0:N-1] sel;
    logic [0:N-1]        gnt;

    int checks = 0;
    int errors = 0;
    bit inv_en = 1'b0;

    lib_allocator_onehot_rr #(.N(N), .M(M)) dut (
        .clk    (clk),
        .reset  (reset),
        .i_ce   (ce),
        .i_req  (req),
        .i_last (last),
        .o_sel  (sel),
        .o_gnt  (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:N-1] oh(input int n);
        logic [0:N-1] v;
        for (int i = 0; i < N; i++) begin
            v[i] = (i == n);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-hot rows, one output per input, and o_gnt consistent with o_sel, every cycle.
    always @(negedge clk) begin
        if (inv_en) begin
            int col_cnt;
            for (int m = 0; m < M; m++) begin
                checks++;
                if ($countones(sel[m]) > 1) begin
                    errors++;
                    $display("FAIL sel_onehot row %0d: got %b required at most one bit", m, sel[m]);
                end
            end
            for (int n = 0; n < N; n++) begin
                col_cnt = 0;
                for (int m = 0; m < M; m++) begin
                    if (sel[m][n]) col_cnt++;
                end
                checks++;
                if (col_cnt > 1 || gnt[n] !== (col_cnt == 1)) begin
                    errors++;
                    $display("FAIL gnt_column %0d: got gnt=%b with %0d selects, required gnt=OR and at most one", n, gnt[n], col_cnt);
                end
            end
        end
    end

    task automatic cleanup();
        req  = '0;
        last = '0;
        ce   = 1'b1;
        tick();
        tick();
        checks++;
        if (sel !== '0 || gnt !== '0) begin
            errors++;
            $display("FAIL cleanup_idle: got sel=%b gnt=%b required all zero", sel, gnt);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (sel !== '0 || gnt !== '0) begin
            errors++;
            $display("FAIL reset_initial: got sel=%b gnt=%b required zero", sel, gnt);
        end
        tick();
        tick();
        reset  = 1'b0;
        inv_en = 1'b1;
        req[2][3] = 1'b1;
        tick();
        checks++;
        if (sel[3] !== oh(2) || gnt !== oh(2)) begin
            errors++;
            $display("FAIL reset_pregrant: got sel[3]=%b gnt=%b required %b", sel[3], gnt, oh(2));
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (sel !== '0 || gnt !== '0) begin
            errors++;
            $display("FAIL reset_async: got sel=%b gnt=%b required zero before any edge", sel, gnt);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = '0;
        req[3][1] = 1'b1;
        tick();
        checks++;
        if (sel[1] !== oh(3) || sel[3] !== '0 || gnt !== oh(3)) begin
            errors++;
            $display("FAIL reset_restart: got sel[1]=%b sel[3]=%b gnt=%b required %b / 0 / %b",
                     sel[1], sel[3], gnt, oh(3), oh(3));
        end
        cleanup();
    endtask

    task automatic test_multi_bit();
        req[0][1] = 1'b1;
        req[0][3] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (sel[1] !== oh(0) || sel[3] !== '0 || gnt !== oh(0)) begin
                errors++;
                $display("FAIL multi_bit cycle %0d: got sel[1]=%b sel[3]=%b gnt=%b required %b / 0 / %b",
                         k, sel[1], sel[3], gnt, oh(0), oh(0));
            end
        end
        cleanup();
    endtask

`ifdef ALLOC_PACKET_LOCK_EN
    task automatic test_packet_rr();
        int           exp_seq [15] = '{0, 0, 0, -1, 2, 2, 2, -1, 4, 4, 4, -1, 0, 0, 0};
        logic [0:N-1] exp_row;
        req[0][0] = 1'b1;
        req[2][0] = 1'b1;
        req[4][0] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            exp_row = (exp_seq[k] < 0) ? '0 : oh(exp_seq[k]);
            checks++;
            if (sel[0] !== exp_row || gnt !== exp_row) begin
                errors++;
                $display("FAIL packet_rr cycle %0d: got sel[0]=%b gnt=%b required %b", k, sel[0], gnt, exp_row);
            end
            last = (k % 4 == 2) ? '1 : '0;
        end
        cleanup();
    endtask

    task automatic test_req_drop();
        req[1][2] = 1'b1;
        tick();
        tick();
        checks++;
        if (sel[2] !== oh(1)) begin
            errors++;
            $display("FAIL drop_locked: got sel[2]=%b required %b", sel[2], oh(1));
        end
        req[1][2] = 1'b0;
        tick();
        checks++;
        if (sel[2] !== '0 || gnt !== '0) begin
            errors++;
            $display("FAIL drop_release: got sel[2]=%b gnt=%b required zero", sel[2], gnt);
        end
        req[0][2] = 1'b1;
        req[1][2] = 1'b1;
        req[2][2] = 1'b1;
        tick();
        checks++;
        if (sel[2] !== oh(2)) begin
            errors++;
            $display("FAIL drop_ptr: got sel[2]=%b required %b", sel[2], oh(2));
        end
        cleanup();
    endtask

    task automatic test_ce_hold();
        req[3][4] = 1'b1;
        tick();
        ce      = 1'b0;
        last[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (sel[4] !== oh(3) || gnt !== oh(3)) begin
                errors++;
                $display("FAIL ce_hold cycle %0d: got sel[4]=%b gnt=%b required %b", k, sel[4], gnt, oh(3));
            end
        end
        ce = 1'b1;
        tick();
        checks++;
        if (sel[4] !== '0) begin
            errors++;
            $display("FAIL ce_release: got sel[4]=%b required zero", sel[4]);
        end
        last = '0;
        req[0][4] = 1'b1;
        req[4][4] = 1'b1;
        tick();
        checks++;
        if (sel[4] !== oh(4)) begin
            errors++;
            $display("FAIL ce_ptr: got sel[4]=%b required %b", sel[4], oh(4));
        end
        cleanup();
    endtask
`else
    task automatic test_flit_alternate();
        req[1][4] = 1'b1;
        req[3][4] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (sel[4] !== oh((k % 2 == 0) ? 1 : 3)) begin
                errors++;
                $display("FAIL flit_alt cycle %0d: got sel[4]=%b required %b", k, sel[4], oh((k % 2 == 0) ? 1 : 3));
            end
        end
        cleanup();
    endtask

    task automatic test_flit_all();
        for (int n = 0; n < N; n++) begin
            req[n][0] = 1'b1;
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (sel[0] !== oh(k % N)) begin
                errors++;
                $display("FAIL flit_all cycle %0d: got sel[0]=%b required %b", k, sel[0], oh(k % N));
            end
        end
        cleanup();
    endtask

    task automatic test_flit_ce();
        req[1][4] = 1'b1;
        req[3][4] = 1'b1;
        tick();
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (sel[4] !== oh(1)) begin
                errors++;
                $display("FAIL flit_ce_hold cycle %0d: got sel[4]=%b required %b", k, sel[4], oh(1));
            end
        end
        ce = 1'b1;
        tick();
        checks++;
        if (sel[4] !== oh(3)) begin
            errors++;
            $display("FAIL flit_ce_resume: got sel[4]=%b required %b", sel[4], oh(3));
        end
        req = '0;
        req[2][2] = 1'b1;
        tick();
        req = '0;
        tick();
        checks++;
        if (sel[2] !== '0 || gnt !== '0) begin
            errors++;
            $display("FAIL flit_drop: got sel[2]=%b gnt=%b required zero", sel[2], gnt);
        end
        cleanup();
    endtask
`endif

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        req   = '0;
        last  = '0;
        test_reset();
`ifdef ALLOC_PACKET_LOCK_EN
        test_packet_rr();
        test_req_drop();
        test_ce_hold();
`else
        test_flit_alternate();
        test_flit_all();
        test_flit_ce();
`endif
        test_multi_bit();
        inv_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
